audio_stream_scheduler: RTL
===========================

// Module: audio_stream_scheduler
// PURPOSE
//  Paces the audio datapath at the codec frame rate (48 kHz from the 36.864 MHz clock).
//  Pulls synth samples through a valid/ready handshake and buffers them in a small FIFO.
//  Selects synth or line-in loopback as the source and presents one sample per frame,
//  held stable, to the I2S transmitter. Sits between the synth voice mixer and the PMOD I2S2 codec interface.
// PARAMETERS
//  SAMPLE_DIV     768          clk_in cycles per audio frame (36.864 MHz / 48 kHz)
//  FIFO_DEPTH     8            synth sample FIFO entries, power of two, >= 2
//  PRIME_LEVEL    4            FIFO occupancy required before streaming starts, 1..FIFO_DEPTH
//  UNDERRUN_MUTE  1            1: underrun outputs 0; 0: underrun repeats last sample
// PORTS
//  clk_in             in   1                        system clock; single clock domain
//  rst_n_in           in   1                        asynchronous active-low reset
//  enable_in          in   1                        level; 1 = stream, 0 = stop at next frame boundary
//  src_sel_in         in   1                        0 = synth, 1 = line-in loopback; sampled only at frame tick
//  synth_sample_in    in   SYNTH_WIDTH              synth sample, two's complement
//  synth_valid_in     in   1                        synth sample available
//  synth_ready_out    out  1                        FIFO will accept a sample this cycle
//  lin_sample_in      in   SYNTH_WIDTH              captured line-in sample
//  lin_valid_in       in   1                        1-cycle pulse: lin_sample_in is new
//  frame_tick_out     out  1                        1-cycle pulse, once per frame in RUN
//  tx_sample_out      out  SYNTH_WIDTH              sample to the transmitter, held for the whole frame
//  tx_valid_out       out  1                        1 from the first RUN tick until return to IDLE
//  fifo_level_out     out  $clog2(FIFO_DEPTH+1)     current FIFO occupancy
//  underrun_count_out out  16                       saturating count of empty-FIFO ticks
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0; FIFO empty; lin holding register 0.
//  States:
//   IDLE  -> PRIME when enable_in=1.
//   PRIME -> RUN   when fifo_level >= PRIME_LEVEL, or immediately if src_sel_in=1.
//   PRIME -> IDLE  if enable_in drops.
//   RUN   -> IDLE  on the frame tick after enable_in=0 is seen; the current frame completes;
//                  FIFO is flushed on entry to IDLE.
//  Frame counter: cleared on RUN entry; counts 0..SAMPLE_DIV-1; wraps; tick when count==SAMPLE_DIV-1.
//   The first tick comes exactly SAMPLE_DIV cycles after the PRIME->RUN edge. The counter is held at 0 outside RUN.
//  At tick (registered, same edge):
//   - frame_tick_out=1 for exactly one cycle.
//   - tx_sample_out loads the new sample; tx_valid_out=1.
//   - src_sel is latched for the next frame.
//  Synth source:
//   - tick pops the FIFO head into tx_sample_out.
//   - FIFO empty at tick = underrun: tx_sample_out=0 if UNDERRUN_MUTE, else unchanged;
//     underrun_count_out += 1, saturating at 16'hFFFF; the state stays RUN.
//  Line-in source:
//   - lin_valid_in loads the holding register; tick copies the holding register to tx_sample_out.
//   - The FIFO is neither pushed nor popped; synth_ready_out=0.
//   - If lin_valid_in and tick coincide, the new lin_sample_in is what is output.
//  Handshake:
//   - synth_ready_out = (state is PRIME or RUN) && latched src_sel==0 && FIFO not full; registered-state function, no comb path from valid.
//   - A push occurs on valid&&ready.
//   - A push and a tick-pop in the same cycle both take effect; level is unchanged.
//   - Full FIFO: ready=0 even on a pop cycle.
//  FIFO pointers: log2(FIFO_DEPTH) bits, wrap naturally; level = count register, 0..FIFO_DEPTH.
//  Mid-operation rst_n_in low: immediate return to reset values, no frame completion.
// STRUCTURE
//  constants package additions: SAMPLE_DIV_48K=768; typedef enum logic [1:0] {IDLE,PRIME,RUN} stream_state_t.
//  Sub-module: sample_fifo (single-clock FIFO, width SYNTH_WIDTH, depth FIFO_DEPTH; push/pop/full/empty/level, flush).
//  Top: state machine, frame counter, source mux, tx_sample register, underrun counter.
// TESTING (bench uses SAMPLE_DIV=16, FIFO_DEPTH=4, PRIME_LEVEL=2, SYNTH_WIDTH=24)
//  1. Reset mid-RUN, then release -> all outputs 0, state IDLE, fifo_level_out=0, no tick for 64 cycles.
//  2. enable=1, push 24'h000001, 24'h000002 -> RUN. First tick 16 cycles after RUN entry: tx_sample=24'h000001, tx_valid=1.
//     The next tick gives 24'h000002. Tick spacing is exactly 16 cycles.
//  3. Synth valid held high with 24'h0000AA:
//     - level stops at 4 and ready=0;
//     - on a tick, pop+no push, then level goes 3 -> 4.
//  4. Starve the FIFO after 2 samples -> third tick: tx_sample=0 (MUTE=1) and underrun_count=1.
//     Repeat with MUTE=0 -> tx_sample holds 24'h000002.
//  5. src_sel=1, lin_valid pulse with 24'h7FFFFF -> next tick gives tx_sample=24'h7FFFFF and synth_ready=0.
//     A lin_valid coinciding with the tick using 24'h800000 -> that tick outputs 24'h800000.
//  6. Drop enable mid-frame -> exactly one more tick, then IDLE.
//     tx_valid=0 the cycle after; fifo_level=0; the underrun count is preserved.

Source files
------------

// File: rtl/audio_stream_scheduler_pkg.sv
// Shared constants and types for the audio stream scheduler.
package audio_stream_scheduler_pkg;

  localparam int unsigned SAMPLE_DIV_48K      = 768;
  localparam int unsigned FIFO_DEPTH_DEFAULT  = 8;
  localparam int unsigned PRIME_LEVEL_DEFAULT = 4;
  localparam int unsigned SYNTH_WIDTH_DEFAULT = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } stream_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_stream_scheduler_fifo.sv
// Single-clock sample FIFO with occupancy count and synchronous flush.
module sample_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       flush_in,
  input  logic                       push_in,
  input  logic [WIDTH-1:0]           push_data_in,
  input  logic                       pop_in,
  output logic [WIDTH-1:0]           head_c,
  output logic                       empty_c,
  output logic [$clog2(DEPTH+1)-1:0] level_out,
  output logic [$clog2(DEPTH+1)-1:0] level_next_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_c;
  logic             push_ok, pop_ok;

  assign full_c       = (level_q == LVL_W'(DEPTH));
  assign empty_c      = (level_q == '0);
  assign head_c       = mem_q[rd_ptr_q];
  assign level_out    = level_q;
  assign level_next_c = level_d;

  always_comb begin
    push_ok  = push_in && !full_c;
    pop_ok   = pop_in && !empty_c;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/audio_stream_scheduler.sv
// Frame-rate pacer: buffers synth samples, selects synth or line-in, and
// presents one held sample per frame to the I2S transmitter.
module audio_stream_scheduler
  import audio_stream_scheduler_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV    = SAMPLE_DIV_48K,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEFAULT,
  parameter int unsigned PRIME_LEVEL   = PRIME_LEVEL_DEFAULT,
  parameter int unsigned UNDERRUN_MUTE = 1,
  parameter int unsigned SYNTH_WIDTH   = SYNTH_WIDTH_DEFAULT
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            enable_in,
  input  logic                            src_sel_in,
  input  logic [SYNTH_WIDTH-1:0]          synth_sample_in,
  input  logic                            synth_valid_in,
  output logic                            synth_ready_out,
  input  logic [SYNTH_WIDTH-1:0]          lin_sample_in,
  input  logic                            lin_valid_in,
  output logic                            frame_tick_out,
  output logic [SYNTH_WIDTH-1:0]          tx_sample_out,
  output logic                            tx_valid_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_out,
  output logic [15:0]                     underrun_count_out
);

  localparam int unsigned CNT_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  stream_state_t          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   tick_q, tick_d;
  logic [SYNTH_WIDTH-1:0] tx_sample_q, tx_sample_d;
  logic                   tx_valid_q, tx_valid_d;
  logic                   src_sel_q, src_sel_d;
  logic [SYNTH_WIDTH-1:0] lin_hold_q, lin_hold_d;
  logic [15:0]            underrun_q, underrun_d;
  logic                   ready_q, ready_d;
  logic                   stop_pend_q, stop_pend_d;

  logic                   tick_c, push_c, pop_c, flush_c, underrun_c;
  logic [SYNTH_WIDTH-1:0] fifo_head;
  logic                   fifo_empty;
  logic [LVL_W-1:0]       fifo_level, fifo_level_next;

  sample_fifo #(
    .WIDTH (SYNTH_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .flush_in     (flush_c),
    .push_in      (push_c),
    .push_data_in (synth_sample_in),
    .pop_in       (pop_c),
    .head_c       (fifo_head),
    .empty_c      (fifo_empty),
    .level_out    (fifo_level),
    .level_next_c (fifo_level_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    stop_pend_d = stop_pend_q;
    src_sel_d   = src_sel_q;
    tx_sample_d = tx_sample_q;
    tx_valid_d  = tx_valid_q;
    underrun_d  = underrun_q;
    lin_hold_d  = lin_valid_in ? lin_sample_in : lin_hold_q;

    tick_c     = (state_q == RUN) && (cnt_q == CNT_W'(SAMPLE_DIV - 1));
    push_c     = synth_valid_in && ready_q;
    pop_c      = tick_c && !src_sel_q && !fifo_empty;
    underrun_c = tick_c && !src_sel_q && fifo_empty;

    case (state_q)
      IDLE: begin
        if (enable_in) state_d = PRIME;
      end
      PRIME: begin
        if (!enable_in) state_d = IDLE;
        else if ((fifo_level >= LVL_W'(PRIME_LEVEL)) || src_sel_in) state_d = RUN;
      end
      RUN: begin
        // A stop request is remembered so the current frame always completes.
        if (!enable_in) stop_pend_d = 1'b1;
        if (tick_c && (stop_pend_q || !enable_in)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != RUN) stop_pend_d = 1'b0;
    flush_c = (state_q != IDLE) && (state_d == IDLE);

    if ((state_q == RUN) && (state_d == RUN)) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    if ((state_q != RUN) || tick_c) src_sel_d = src_sel_in;

    if (tick_c) begin
      if (src_sel_q) begin
        tx_sample_d = lin_valid_in ? lin_sample_in : lin_hold_q;
      end else if (!fifo_empty) begin
        tx_sample_d = fifo_head;
      end else if (UNDERRUN_MUTE != 0) begin
        tx_sample_d = '0;
      end
    end

    if (state_q == IDLE) tx_valid_d = 1'b0;
    else if (tick_c)     tx_valid_d = 1'b1;

    if (underrun_c) underrun_d = sat_inc16(underrun_q);

    // Ready is computed from next-cycle state so it can be a plain flop.
    ready_d = ((state_d == PRIME) || (state_d == RUN)) && !src_sel_d &&
              (fifo_level_next != LVL_W'(FIFO_DEPTH));
    tick_d  = tick_c;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      tx_sample_q <= '0;
      tx_valid_q  <= 1'b0;
      src_sel_q   <= 1'b0;
      lin_hold_q  <= '0;
      underrun_q  <= '0;
      ready_q     <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      tx_sample_q <= tx_sample_d;
      tx_valid_q  <= tx_valid_d;
      src_sel_q   <= src_sel_d;
      lin_hold_q  <= lin_hold_d;
      underrun_q  <= underrun_d;
      ready_q     <= ready_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign synth_ready_out    = ready_q;
  assign frame_tick_out     = tick_q;
  assign tx_sample_out      = tx_sample_q;
  assign tx_valid_out       = tx_valid_q;
  assign fifo_level_out     = fifo_level;
  assign underrun_count_out = underrun_q;

endmodule
